uart_recv: RTL and testbench

UART_RECV -- requirements
Module: uart_recv

---
 rtl/uart_recv.sv | 180 ++++++++++++++++++
 tb/tb_uart_recv.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_recv.sv
// uart_recv -- 8N1 UART receiver with 2-flop input synchronizer.
//
// Receives LSB-first 8-bit frames: one start bit, eight data bits and
// one stop bit. Each bit is sampled in its centre. The start bit is
// confirmed half a bit period after the falling edge. After that, each
// later sample is taken a full bit period after the previous one.
//
// Optional feature macro: UART_RX_FRAME_ERR_EN
//   When defined, a low stop sample is treated as a framing error. In
//   that case RX_Frame_Err pulses, RX_DV stays low and RX_BYTE is not
//   updated.
//   When undefined, the RX_Frame_Err port does not exist. Every frame
//   then updates RX_BYTE and pulses RX_DV, whatever the stop sample.
//
// Parameters
//   CLKS_PER_BITS  clocks per bit period (4..65535), default 217
//                  (25 MHz / 115200 baud)
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   RX_serial     serial input line, idles high
//   RX_DV         one-cycle pulse: RX_BYTE holds a freshly received byte
//   RX_BYTE       last accepted byte; holds until the next accepted frame
//   RX_Active     high from the confirmed start bit until the stop sample
//   RX_Frame_Err  one-cycle pulse on a low stop sample (macro builds only)

module uart_recv #(
    parameter int CLKS_PER_BITS = 217
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX_serial,
    output logic       RX_DV,
    output logic [7:0] RX_BYTE,
    output logic       RX_Active
`ifdef UART_RX_FRAME_ERR_EN
    ,
    output logic       RX_Frame_Err
`endif
);

    localparam logic [15:0] LAST = 16'(CLKS_PER_BITS - 1);
    localparam logic [15:0] HALF = 16'((CLKS_PER_BITS - 1) / 2);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_BIT = 3'd1,
        DATA_BITS = 3'd2,
        STOP_BITS = 3'd3,
        CLEAN_UP  = 3'd4
    } state_t;

    state_t      state;
    logic [15:0] counter;
    logic [2:0]  bit_index;
    logic [7:0]  shift;
    logic        sync1;
    logic        rx_s;
    // Set by a low stop sample. While it is set, IDLE waits for the line
    // to go high again before it looks for a start bit. Without it, a
    // line held low would be taken as an endless run of 0x00 frames.
    logic        wait_high;

    // Both synchronizer flops reset to the idle (high) level. As a
    // result, rx_s cannot show a low level until the second edge after
    // reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= RX_serial;
            rx_s  <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            counter      <= 16'd0;
            bit_index    <= 3'd0;
            shift        <= 8'h00;
            RX_BYTE      <= 8'h00;
            RX_DV        <= 1'b0;
            RX_Active    <= 1'b0;
            wait_high    <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
            RX_Frame_Err <= 1'b0;
`endif
        end else begin
            // Pulse outputs default low; they are raised only on the
            // stop-sample edge.
            RX_DV        <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
            RX_Frame_Err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    counter   <= 16'd0;
                    bit_index <= 3'd0;
                    if (wait_high) begin
                        if (rx_s)
                            wait_high <= 1'b0;
                    end else if (!rx_s) begin
                        state <= START_BIT;
                    end
                end

                START_BIT: begin
                    if (counter == HALF) begin
                        counter <= 16'd0;
                        if (!rx_s) begin
                            RX_Active <= 1'b1;
                            state     <= DATA_BITS;
                        end else begin
                            // The line went high again: this was a glitch,
                            // not a start bit.
                            state <= IDLE;
                        end
                    end else begin
                        counter <= counter + 16'd1;
                    end
                end

                DATA_BITS: begin
                    if (counter == LAST) begin
                        counter          <= 16'd0;
                        shift[bit_index] <= rx_s;
                        if (bit_index == 3'd7) begin
                            bit_index <= 3'd0;
                            state     <= STOP_BITS;
                        end else begin
                            bit_index <= bit_index + 3'd1;
                        end
                    end else begin
                        counter <= counter + 16'd1;
                    end
                end

                STOP_BITS: begin
                    if (counter == LAST) begin
                        counter   <= 16'd0;
                        RX_Active <= 1'b0;
                        state     <= CLEAN_UP;
                        if (!rx_s)
                            wait_high <= 1'b1;
`ifdef UART_RX_FRAME_ERR_EN
                        if (rx_s) begin
                            RX_BYTE <= shift;
                            RX_DV   <= 1'b1;
                        end else begin
                            RX_Frame_Err <= 1'b1;
                        end
`else
                        RX_BYTE <= shift;
                        RX_DV   <= 1'b1;
`endif
                    end else begin
                        counter <= counter + 16'd1;
                    end
                end

                CLEAN_UP: begin
                    // A single-cycle gap that ignores the line. A start
                    // bit arriving here is picked up once back in IDLE.
                    counter <= 16'd0;
                    state   <= IDLE;
                end

                default: begin
                    counter   <= 16'd0;
                    bit_index <= 3'd0;
                    RX_Active <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_recv.sv
// tb_uart_recv -- scoreboard bench for uart_recv at CLKS_PER_BITS=217.
// The stimulus process serialises frames and queues the response each
// one should produce. An independent monitor checks every RX_DV or
// RX_Frame_Err pulse against the head of that queue.

module tb_uart_recv;

    localparam int CPB = 217;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       RX_serial;
    logic       RX_DV;
    logic [7:0] RX_BYTE;
    logic       RX_Active;
    logic       ferr;

    always #5 clk = ~clk;

`ifdef UART_RX_FRAME_ERR_EN
    uart_recv #(.CLKS_PER_BITS(CPB)) dut (
        .clk(clk), .rst_n(rst_n), .RX_serial(RX_serial), .RX_DV(RX_DV),
        .RX_BYTE(RX_BYTE), .RX_Active(RX_Active), .RX_Frame_Err(ferr));
`else
    uart_recv #(.CLKS_PER_BITS(CPB)) dut (
        .clk(clk), .rst_n(rst_n), .RX_serial(RX_serial), .RX_DV(RX_DV),
        .RX_BYTE(RX_BYTE), .RX_Active(RX_Active));
    assign ferr = 1'b0;
`endif

    typedef struct {
        bit         is_err;
        logic [7:0] b;
        bit         lat;
        bit         gap;
        int         t0;
    } exp_t;

    exp_t       q[$];
    int         n_chk = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         last_dv = 0;
    int         dv_cnt = 0;
    bit         act_seen = 0;
    logic [7:0] last_good = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        n_chk++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    // Monitor: all checks on output pulses happen here.
    always @(negedge clk) begin
        if (rst_n) begin
            if (RX_Active) act_seen = 1;
            if (RX_DV || ferr) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_pulse actual dv=%0b err=%0b byte=%0h required none",
                             RX_DV, ferr, RX_BYTE);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("pulse_kind", {30'd0, ferr, RX_DV}, e.is_err ? 32'd2 : 32'd1);
                    chk("rx_byte", {24'd0, RX_BYTE}, {24'd0, e.b});
                    if (e.lat) chk_rng("dv_latency", cyc - e.t0, 2060, 2066);
                    if (e.gap) chk_rng("b2b_gap", cyc - last_dv, 2168, 2172);
                end
                if (RX_DV) begin
                    last_dv = cyc;
                    dv_cnt++;
                end
            end
        end
    end

    // Drive level b for n clocks. Each call starts and ends 1 time unit
    // after a rising edge.
    task automatic line(input logic b, input int n);
        RX_serial = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic stop, input bit lat, input bit gap);
        exp_t e;
        e.is_err = 0;
        e.b      = d;
        e.lat    = lat;
        e.gap    = gap;
        e.t0     = cyc;
`ifdef UART_RX_FRAME_ERR_EN
        if (!stop) begin
            e.is_err = 1;
            e.b      = last_good;
        end else begin
            last_good = d;
        end
`else
        last_good = d;
`endif
        q.push_back(e);
        line(1'b0, CPB);
        for (int i = 0; i < 8; i++) line(d[i], CPB);
        line(stop, CPB);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 4000) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout actual pending=%0d required 0", q.size());
            q.delete();
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        @(negedge clk);
        chk({tag, "_dv"}, {31'd0, RX_DV}, 32'd0);
        chk({tag, "_byte"}, {24'd0, RX_BYTE}, 32'd0);
        chk({tag, "_active"}, {31'd0, RX_Active}, 32'd0);
        chk({tag, "_ferr"}, {31'd0, ferr}, 32'd0);
    endtask

    initial begin
        logic [7:0] d96;
        int         dv0;
        d96       = 8'h96;
        rst_n     = 1'b0;
        RX_serial = 1'b1;
        repeat (5) @(posedge clk);
        chk_reset_outs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        line(1'b1, 20);

        // Loopback bytes with latency check
        send(8'h00, 1'b1, 1, 0); line(1'b1, 300); wait_drain();
        send(8'hFF, 1'b1, 1, 0); line(1'b1, 300); wait_drain();
        send(8'hA5, 1'b1, 1, 0); line(1'b1, 300); wait_drain();
        send(8'h3C, 1'b1, 1, 0); line(1'b1, 300); wait_drain();

        // Back-to-back frames with no idle gap
        send(8'h55, 1'b1, 0, 0);
        send(8'hAA, 1'b1, 0, 1);
        line(1'b1, 300);
        wait_drain();

        // 50-clock low glitch on an idle line
        act_seen = 0;
        dv0      = dv_cnt;
        line(1'b0, 50);
        line(1'b1, 400);
        chk("glitch_active", {31'd0, act_seen}, 32'd0);
        chk("glitch_dv_count", dv_cnt, dv0);

        // Frame 0xC3 with a low stop bit
        send(8'hC3, 1'b0, 0, 0);
        line(1'b1, 400);
        wait_drain();

        // Line held low: exactly one response, then no re-arm until high
        begin
            exp_t e;
            e.lat = 0;
            e.gap = 0;
            e.t0  = cyc;
`ifdef UART_RX_FRAME_ERR_EN
            e.is_err = 1;
            e.b      = last_good;
`else
            e.is_err  = 0;
            e.b       = 8'h00;
            last_good = 8'h00;
`endif
            q.push_back(e);
        end
        dv0 = dv_cnt;
        line(1'b0, 6000);
        line(1'b1, 400);
        wait_drain();
`ifdef UART_RX_FRAME_ERR_EN
        chk("held_low_dv_count", dv_cnt, dv0);
`else
        chk("held_low_dv_count", dv_cnt, dv0 + 1);
`endif

        // Reset during data bit 4 of 0x96, then 0x69
        line(1'b0, CPB);
        for (int i = 0; i < 4; i++) line(d96[i], CPB);
        line(d96[4], 100);
        rst_n = 1'b0;
        line(d96[4], 3);
        chk_reset_outs("midrst");
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        last_good = 8'h00;
        line(1'b1, 500);
        dv0 = dv_cnt;
        send(8'h69, 1'b1, 1, 0);
        line(1'b1, 300);
        wait_drain();
        chk("after_reset_dv_count", dv_cnt, dv0 + 1);

        chk("final_queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
